// File: rtl/fetch_unit_pq.sv
// Instruction fetch unit: credit-limited pipelined imem requests, in-order prefetch
// queue toward decode, and branch/jump redirect that squashes in-flight responses.
module fetch_unit_pq #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 4,
  parameter int              BIMM_W   = 13,
  parameter int              JIMM_W   = 21
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [XLEN-1:0]   imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [XLEN-1:0]   instr,
  output logic [XLEN-1:0]   instr_pc,
  input  logic              br_taken,
  input  logic              jmp,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [BIMM_W-1:0] br_imm,
  input  logic [JIMM_W-1:0] jmp_imm,
  output logic              misaligned
);
  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t [QDEPTH-1:0] q_mem_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, shadow_q, shadow_d;
  logic [AW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]   cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
  logic            mis_q, mis_d;

  logic            redirect, req_fire, keep, pop;
  logic [XLEN-1:0] offset, target;
  logic [CW:0]     inuse;

  assign redirect = br_taken | jmp;
  assign offset   = br_taken ? {{(XLEN-BIMM_W){br_imm[BIMM_W-1]}}, br_imm}
                             : {{(XLEN-JIMM_W){jmp_imm[JIMM_W-1]}}, jmp_imm};
  assign target   = ex_pc + offset;

  // Outstanding fetches hold a queue slot in reserve, so a response always has room.
  assign inuse          = {1'b0, out_q} + {1'b0, cnt_q};
  assign imem_req_valid = !reset && !redirect && (inuse < (CW+1)'(QDEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign keep           = imem_rsp_valid && (drop_q == '0) && !redirect;
  assign pop            = instr_valid && instr_ready && !redirect;

  assign instr_valid = (cnt_q != '0);
  assign instr       = q_mem_q[rptr_q].data;
  assign instr_pc    = q_mem_q[rptr_q].pc;
  assign misaligned  = mis_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    shadow_d   = shadow_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    cnt_d      = cnt_q;
    out_d      = out_q - CW'(imem_rsp_valid);
    drop_d     = drop_q;
    mis_d      = 1'b0;
    if (redirect) begin
      fetch_pc_d = {target[XLEN-1:2], 2'b00};
      shadow_d   = {target[XLEN-1:2], 2'b00};
      rptr_d     = '0;
      wptr_d     = '0;
      cnt_d      = '0;
      // A response landing in the redirect cycle is itself stale and squashed here.
      drop_d     = out_q - CW'(imem_rsp_valid);
      mis_d      = (target[1:0] != 2'b00);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        out_d      = out_q + CW'(1) - CW'(imem_rsp_valid);
      end
      if (imem_rsp_valid && (drop_q != '0))
        drop_d = drop_q - CW'(1);
      if (keep) begin
        wptr_d   = wptr_q + AW'(1);
        shadow_d = shadow_q + XLEN'(4);
      end
      if (pop)
        rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q + CW'(keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      shadow_q   <= RESET_PC;
      rptr_q     <= '0;
      wptr_q     <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      mis_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      shadow_q   <= shadow_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      mis_q      <= mis_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && keep)
      q_mem_q[wptr_q] <= '{pc: shadow_q, data: imem_rsp_data};
  end

endmodule

// File: tb/tb_fetch_unit_pq.sv
// Bench for fetch_unit_pq: random in-order memory, queue-level reference model,
// per-cycle output compare, plus directed literal checks.
module tb_fetch_unit_pq;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic        br_taken = 1'b0, jmp = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [12:0] br_imm = '0;
  logic [20:0] jmp_imm = '0;
  logic        misaligned;

  always #5 clk = ~clk;

  fetch_unit_pq #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(QD), .BIMM_W(13), .JIMM_W(21)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .br_taken(br_taken), .jmp(jmp), .ex_pc(ex_pc), .br_imm(br_imm), .jmp_imm(jmp_imm),
    .misaligned(misaligned)
  );

  int total = 0, bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] memf(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  // reference model state (starts at reset values)
  logic [31:0] m_fpc = '0, m_sh = '0;
  logic [31:0] mq_pc[$], mq_dat[$];
  int          m_out = 0, m_drop = 0;
  bit          m_mis = 0;

  // memory model
  logic [31:0] mem_a[$];
  int          mem_due[$];
  int          last_due = 0, cyc = 0;

  // knobs and samples
  bit          rst_v = 0, br_v = 0, jmp_v = 0;
  int          rdy_p = 100, ir_p = 100, lat_lo = 1, lat_hi = 1;
  logic [31:0] exv = '0;
  logic [12:0] bimm = '0;
  logic [20:0] jimm = '0;
  bit          s_rv, s_iv, s_mis;
  logic [31:0] s_addr, s_ipc, s_instr, first_acc;
  int          acc_cnt = 0;

  task automatic step();
    bit rsp, erv, red, pop, acc;
    logic [31:0] rdat, tgt;
    int d;
    @(negedge clk);
    rsp  = !rst_v && mem_a.size() > 0 && mem_due[0] <= cyc;
    rdat = rsp ? memf(mem_a[0]) : $urandom;
    reset          = rst_v;
    imem_req_ready = ($urandom_range(99) < rdy_p);
    instr_ready    = ($urandom_range(99) < ir_p);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rdat;
    br_taken = br_v; jmp = jmp_v; ex_pc = exv; br_imm = bimm; jmp_imm = jimm;
    #1;
    red = br_v || jmp_v;
    erv = !rst_v && !red && (m_out + mq_pc.size() < QD);
    chk("req_valid", 32'(imem_req_valid), 32'(erv));
    if (erv) chk("req_addr", imem_req_addr, m_fpc);
    chk("instr_valid", 32'(instr_valid), 32'(mq_pc.size() > 0));
    if (mq_pc.size() > 0) begin
      chk("instr_pc", instr_pc, mq_pc[0]);
      chk("instr", instr, mq_dat[0]);
      chk("instr_vs_mem", instr, memf(instr_pc));
    end
    chk("misaligned", 32'(misaligned), 32'(m_mis));
    s_rv = imem_req_valid; s_iv = instr_valid; s_mis = misaligned;
    s_addr = imem_req_addr; s_ipc = instr_pc; s_instr = instr;

    acc = imem_req_valid && imem_req_ready;
    if (rst_v) begin
      mem_a.delete(); mem_due.delete(); last_due = 0;
    end else begin
      if (rsp) begin void'(mem_a.pop_front()); void'(mem_due.pop_front()); end
      if (acc) begin
        d = cyc + $urandom_range(lat_hi, lat_lo);
        if (d <= last_due) d = last_due + 1;
        mem_a.push_back(imem_req_addr); mem_due.push_back(d); last_due = d;
        acc_cnt++;
        if (acc_cnt == 1) first_acc = imem_req_addr;
      end
    end

    pop = (mq_pc.size() > 0) && instr_ready;
    if (rst_v) begin
      m_fpc = '0; m_sh = '0; mq_pc.delete(); mq_dat.delete();
      m_out = 0; m_drop = 0; m_mis = 0;
    end else if (red) begin
      tgt   = exv + (br_v ? {{19{bimm[12]}}, bimm} : {{11{jimm[20]}}, jimm});
      m_fpc = {tgt[31:2], 2'b00};
      m_sh  = m_fpc;
      m_mis = (tgt[1:0] != 2'b00);
      m_out = m_out - int'(rsp);
      m_drop = m_out;
      mq_pc.delete(); mq_dat.delete();
    end else begin
      m_mis = 0;
      if (erv && imem_req_ready) begin m_fpc += 4; m_out++; end
      if (pop) begin void'(mq_pc.pop_front()); void'(mq_dat.pop_front()); end
      if (rsp) begin
        m_out--;
        if (m_drop > 0) m_drop--;
        else begin mq_pc.push_back(m_sh); mq_dat.push_back(rdat); m_sh += 4; end
      end
    end
    cyc++;
    br_v = 0; jmp_v = 0;
  endtask

  task automatic do_reset();
    rst_v = 1; step(); rst_v = 0; acc_cnt = 0;
  endtask

  task automatic wait_iv(string nm, logic [31:0] exp_pc);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (s_iv) got = 1;
    end
    chk({nm, "_timeout"}, 32'(got), 32'd1);
    if (got) chk(nm, s_ipc, exp_pc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // streaming, latency 1
    do_reset();
    step(); chk("t1_addr0", s_addr, 32'h0); chk("t1_rv0", 32'(s_rv), 32'd1);
    step(); chk("t1_addr1", s_addr, 32'h4);
    step(); chk("t1_iv", 32'(s_iv), 32'd1); chk("t1_pc0", s_ipc, 32'h0);
    chk("t1_d0", s_instr, 32'hC0DE_0001);
    step(); chk("t1_pc1", s_ipc, 32'h4); chk("t1_d1", s_instr, 32'hC0DA_0001);
    step(); chk("t1_pc2", s_ipc, 32'h8);

    // back-pressure from decode fills credits
    do_reset(); ir_p = 0;
    repeat (10) step();
    chk("t2_acc", 32'(acc_cnt), 32'd4); chk("t2_rv", 32'(s_rv), 32'd0);
    chk("t2_head", s_ipc, 32'h0);
    ir_p = 100; acc_cnt = 0;
    repeat (12) step();
    chk("t2_resume", first_acc, 32'h10);

    // branch with 3 in flight, latency 3
    lat_lo = 3; lat_hi = 3;
    do_reset();
    repeat (3) step();
    br_v = 1; exv = 32'h40; bimm = 13'h1FF0;
    step();
    step(); chk("t3_addr", s_addr, 32'h30); chk("t3_rv", 32'(s_rv), 32'd1);
    wait_iv("t3_pc", 32'h30);

    // branch beats jump
    lat_lo = 1; lat_hi = 1;
    do_reset(); repeat (2) step();
    br_v = 1; jmp_v = 1; exv = 32'h100; bimm = 13'd8; jimm = 21'h800;
    step();
    step(); chk("t4_addr", s_addr, 32'h108); chk("t4_mis", 32'(s_mis), 32'd0);
    wait_iv("t4_pc", 32'h108);

    // misaligned jump target
    jmp_v = 1; exv = 32'h10; jimm = 21'd6;
    step();
    step(); chk("t5_mis", 32'(s_mis), 32'd1); chk("t5_addr", s_addr, 32'h14);
    step(); chk("t5_mis_clr", 32'(s_mis), 32'd0);

    // PC wrap
    jmp_v = 1; exv = 32'hFFFF_FFF0; jimm = 21'd12;
    step();
    step(); chk("t6_addr", s_addr, 32'hFFFF_FFFC); chk("t6_rv", 32'(s_rv), 32'd1);
    step(); chk("t6_wrap", s_addr, 32'h0);

    // reset with two fetches outstanding
    lat_lo = 3; lat_hi = 3;
    do_reset(); repeat (2) step();
    rst_v = 1; step(); chk("t7_rv_rst", 32'(s_rv), 32'd0);
    rst_v = 0;
    step(); chk("t7_iv", 32'(s_iv), 32'd0); chk("t7_mis", 32'(s_mis), 32'd0);
    chk("t7_addr", s_addr, 32'h0);
    wait_iv("t7_pc", 32'h0);

    // randomized traffic
    rdy_p = 70; ir_p = 60; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(99);
      br_v  = (r < 4);
      jmp_v = (r >= 3 && r < 7);
      rst_v = (r == 99);
      exv = $urandom; bimm = 13'($urandom); jimm = 21'($urandom);
      step();
    end
    rst_v = 0;
    rdy_p = 100; ir_p = 100; lat_lo = 1; lat_hi = 1;
    repeat (200) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
